// File: rtl/timer_dev.sv
// Memory-mapped down-counter timer with one-shot and auto-reload modes.
// Raises a registered interrupt request when the count expires.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned EN_BIT = 0;
  localparam int unsigned IM_BIT = 3;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } state_t;

  state_t              state, state_next;
  logic [CTRL_W-1:0]   ctrl, ctrl_next;
  logic [DATA_W-1:0]   preset, preset_next;
  logic [DATA_W-1:0]   count, count_next;
  logic                pending, pending_next;
  logic                irq_next;

  logic                wr_ctrl;
  logic                wr_preset;
  logic                en;
  logic                reload;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);
  assign en        = ctrl[EN_BIT];
  assign reload    = (ctrl[2:1] == MODE_RELOAD);

  // Next-state and next-register computation; software writes override the FSM.
  always_comb begin
    state_next   = state;
    ctrl_next    = ctrl;
    preset_next  = preset;
    count_next   = count;
    pending_next = pending;

    case (state)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        count_next = preset;
        state_next = CNT;
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (count > DATA_W'(1)) begin
          count_next = count - DATA_W'(1);
        end else begin
          count_next = '0;
          state_next = INT;
        end
      end
      INT: begin
        pending_next = 1'b1;
        if (reload) begin
          state_next = LOAD;
        end else begin
          ctrl_next[EN_BIT] = 1'b0;
          state_next        = IDLE;
        end
      end
    endcase

    // Auto-reload makes pending a single-cycle pulse.
    if (reload && (state != INT)) pending_next = 1'b0;

    if (wr_preset) begin
      preset_next  = din;
      pending_next = 1'b0;
    end

    // A disabling CTRL write stops the timer at once and freezes COUNT.
    if (wr_ctrl) begin
      ctrl_next    = din[CTRL_W-1:0];
      pending_next = 1'b0;
      if (!din[EN_BIT]) begin
        state_next = IDLE;
        count_next = count;
      end
    end

    irq_next = ctrl_next[IM_BIT] & pending_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_next;
      ctrl    <= ctrl_next;
      preset  <= preset_next;
      count   <= count_next;
      pending <= pending_next;
      irq     <= irq_next;
    end
  end

  // Zero-latency register readback.
  always_comb begin
    case (addr)
      ADDR_CTRL:   dout = DATA_W'(ctrl);
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      default:     dout = '0;
    endcase
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-003 SHALL have port addr  input  2  word offset select from the bridge: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused.
REQ-004 SHALL have port we  input  1  write strobe, asserted by the bridge for one cycle per store.
REQ-005 SHALL have port din  input  32  store data.
REQ-006 SHALL have port dout  output  32  read data, combinational from addr.
REQ-007 SHALL have port irq  output  1  interrupt request to the hardware-interrupt input of CP0.

Function
REQ-008 SHALL hold CTRL[3:0]: bit0 EN, bits[2:1] MODE, bit3 IM; a read SHALL return CTRL zero-extended to 32 bits.
REQ-009 SHALL hold PRESET[31:0], which is read/write.
REQ-010 SHALL hold COUNT[31:0], which is read-only; a write with addr=10 SHALL be ignored.
REQ-011 SHALL decode writes as follows: we & addr=00 sets CTRL<=din[3:0]; we & addr=01 sets PRESET<=din; a write with addr=11 has no effect.
REQ-012 SHALL return dout as follows: CTRL / PRESET / COUNT for addr 00 / 01 / 10, and 32'h0 for addr 11, with zero-cycle latency.
REQ-013 SHALL implement an FSM with states IDLE, LOAD, CNT and INT.
REQ-014 SHALL, in IDLE, go to LOAD when EN=1; otherwise it stays in IDLE and holds COUNT.
REQ-015 SHALL, on leaving LOAD, set COUNT<=PRESET and go to CNT.
REQ-016 SHALL, in CNT with EN=0, go to IDLE and hold COUNT.
REQ-017 SHALL, in CNT with EN=1 and COUNT>1, set COUNT<=COUNT-1 and stay in CNT.
REQ-018 SHALL, in CNT with EN=1 and COUNT<=1, set COUNT<=0 and go to INT.
REQ-019 SHALL, in INT with MODE=00 (or reserved MODE 10/11), clear EN, set pending<=1 and go to IDLE.
REQ-020 SHALL, in INT with MODE=01, set pending<=1 and go to LOAD (auto-reload).
REQ-021 SHALL, in MODE=01, clear pending in every cycle where the state is not INT, so pending is a one-cycle pulse.
REQ-022 SHALL, in MODE=00, hold pending until any write to CTRL or PRESET.
REQ-023 SHALL drive irq = IM & pending, registered with no combinational path from din.
REQ-024 SHALL give a CTRL write in the same cycle as the FSM's own EN clear (INT, MODE 00) precedence: the written EN value wins.
REQ-025 SHALL, on a CTRL write with EN=0 while in LOAD, CNT or INT, go to IDLE next cycle with COUNT held; pending is cleared by the write per REQ-022.
REQ-026 SHALL apply a PRESET write during CNT at the next LOAD only; the running COUNT is unaffected.
REQ-027 SHALL apply PRESET=0 as COUNT=0 in CNT, giving INT on the next edge.
REQ-028 SHALL treat COUNT arithmetic as unsigned 32-bit with no wrap below 0.

Reset
REQ-029 SHALL, when reset=0 at a rising edge, set CTRL=0, PRESET=0, COUNT=0, pending=0 and state=IDLE; irq SHALL then be 0.
REQ-030 SHALL make reset dominate any simultaneous write or FSM transition.
REQ-031 SHALL, after reset is released mid-count, require the timer to be re-armed by software (EN=0).

Verification
REQ-032 SHALL be verified by: PRESET=3, then CTRL=4'b1001 at edge e0 -> LOAD at e1; COUNT 3, 2, 1, 0 at e2–e5; irq=1 after e6; CTRL reads 4'b1000.
REQ-033 SHALL be verified by: with irq pending from REQ-032, write PRESET=5 -> irq=0 next edge; COUNT stays 0; state stays IDLE.
REQ-034 SHALL be verified by: PRESET=2, CTRL=4'b1011 -> irq high for exactly one cycle, repeating every 4 cycles (PRESET+2); EN stays 1.
REQ-035 SHALL be verified by: IM=0 run of REQ-032 -> irq stays 0; then write CTRL=4'b1000 -> irq stays 0 and pending is cleared.
REQ-036 SHALL be verified by: mid-count (COUNT=7) write CTRL=0, then write addr=10 with din=32'hFFFF -> state IDLE; COUNT stays 7; reads return CTRL=0, COUNT=7, and addr 11 reads 0.
REQ-037 SHALL be verified by: reset=0 asserted during CNT with COUNT=9 -> all registers 0 and irq 0 at the next edge; no INT after release.
